// File: rtl/gate_pkg.sv
// Shared constants for the two-input gate exerciser: gate_sel encodings,
// truth tables (bit i = f({a,b}=i)) and the sweep FSM state type.
package gate_pkg;

  localparam logic [2:0] SEL_AND  = 3'd0;
  localparam logic [2:0] SEL_NAND = 3'd1;
  localparam logic [2:0] SEL_OR   = 3'd2;
  localparam logic [2:0] SEL_NOR  = 3'd3;
  localparam logic [2:0] SEL_XOR  = 3'd4;
  localparam logic [2:0] SEL_XNOR = 3'd5;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gate_truth_lut.sv
// Combinational expected-output lookup for the latched gate type and vector index.
// Zero latency; sel_valid drops for the unused encodings 6 and 7.
module gate_truth_lut
  import gate_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic [1:0] idx,
  output logic       exp_bit,
  output logic       sel_valid
);

  logic [3:0] tt;

  always_comb begin
    tt        = 4'b0000;
    sel_valid = 1'b1;
    case (gate_sel)
      SEL_AND:  tt = TT_AND;
      SEL_NAND: tt = TT_NAND;
      SEL_OR:   tt = TT_OR;
      SEL_NOR:  tt = TT_NOR;
      SEL_XOR:  tt = TT_XOR;
      SEL_XNOR: tt = TT_XNOR;
      default:  sel_valid = 1'b0;
    endcase
    exp_bit = tt[idx];
  end

endmodule

// File: rtl/gate_exerciser.sv
// Drives the four {a,b} vectors into a gate, checks y after SETTLE_CYCLES per vector.
// done rises 4*(SETTLE_CYCLES+1)+1 edges after the accepting start; start is ignored while busy.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic       bad_sel
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE_CYCLES);

  state_e     state;
  state_e     state_nxt;
  logic [2:0] sel_q;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       drain;
  logic       accept;
  logic       cmp;
  logic       exp_bit;
  logic       sel_valid;

  gate_truth_lut u_lut (
    .gate_sel (sel_q),
    .idx      (idx),
    .exp_bit  (exp_bit),
    .sel_valid(sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // After the last compare the sweep spends one drain cycle in RUN before DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmp       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!sel_valid || drain) state_nxt = ST_DONE;
        else if (cnt == SETTLE_W) cmp = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= 3'd0;
      idx      <= 2'd0;
      cnt      <= 4'd0;
      drain    <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
      bad_sel  <= 1'b0;
    end else if (accept) begin
      sel_q    <= gate_sel;
      idx      <= 2'd0;
      cnt      <= 4'd0;
      drain    <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
      bad_sel  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (!sel_valid) begin
        done    <= 1'b1;
        bad_sel <= 1'b1;
        pass    <= 1'b0;
      end else if (drain) begin
        drain <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_cnt == 3'd0);
        a     <= 1'b0;
        b     <= 1'b0;
      end else begin
        cnt <= cnt + 4'd1;
        if (cmp) begin
          if (y != exp_bit) begin
            err_cnt       <= err_cnt + 3'd1;
            fail_vec[idx] <= 1'b1;
          end
          if (idx == 2'd3) begin
            drain <= 1'b1;
          end else begin
            idx    <= idx + 2'd1;
            cnt    <= 4'd0;
            {a, b} <= idx + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: dut 0 (SETTLE_CYCLES=2) and dut 1 (SETTLE_CYCLES=0) driving NAND gate models.
module tb_gate_exerciser;

  logic       clk;
  logic       rst_n;
  logic       stuck;
  logic       start_v [2];
  logic [2:0] gsel_v  [2];
  logic       a0, b0, y0, a1, b1, y1;
  logic [1:0] ab_v    [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [2:0] err_v   [2];
  logic [3:0] fail_v  [2];
  logic       bad_v   [2];
  int         checks;
  int         failures;

  assign y0 = stuck ? 1'b1 : ~(a0 & b0);
  assign y1 = ~(a1 & b1);
  assign ab_v[0] = {a0, b0};
  assign ab_v[1] = {a1, b1};

  gate_exerciser #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_sel(gsel_v[0]),
    .a(a0), .b(b0), .y(y0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err_v[0]), .fail_vec(fail_v[0]), .bad_sel(bad_v[0])
  );

  gate_exerciser #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_sel(gsel_v[1]),
    .a(a1), .b(b1), .y(y1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err_v[1]), .fail_vec(fail_v[1]), .bad_sel(bad_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "_ab"},   8'(ab_v[u]),   8'd0);
    check({tag, "_busy"}, 8'(busy_v[u]), 8'd0);
    check({tag, "_done"}, 8'(done_v[u]), 8'd0);
    check({tag, "_pass"}, 8'(pass_v[u]), 8'd0);
    check({tag, "_err"},  8'(err_v[u]),  8'd0);
    check({tag, "_fail"}, 8'(fail_v[u]), 8'd0);
    check({tag, "_bad"},  8'(bad_v[u]),  8'd0);
  endtask

  // Full sweep on dut u; poke >= 0 pulses start (with AND selected) at that RUN cycle.
  task automatic sweep(input int u, input int s, input logic [2:0] sel, input int poke,
                       input logic [2:0] e_err, input logic [3:0] e_fail, input logic e_pass,
                       input string tag);
    start_v[u] = 1'b1;
    gsel_v[u]  = sel;
    tick();
    start_v[u] = 1'b0;
    for (int n = 0; n < 4 * (s + 1); n++) begin
      if ((n % (s + 1) == 0) || (n % (s + 1) == s)) begin
        check({tag, "_ab"},   8'(ab_v[u]),   8'(n / (s + 1)));
        check({tag, "_busy"}, 8'(busy_v[u]), 8'd1);
        check({tag, "_done"}, 8'(done_v[u]), 8'd0);
      end
      if (n == poke) begin
        start_v[u] = 1'b1;
        gsel_v[u]  = 3'd0;
      end
      tick();
      start_v[u] = 1'b0;
    end
    check({tag, "_done_early"}, 8'(done_v[u]), 8'd0);
    tick();
    check({tag, "_done"}, 8'(done_v[u]), 8'd1);
    check({tag, "_busy"}, 8'(busy_v[u]), 8'd0);
    check({tag, "_pass"}, 8'(pass_v[u]), 8'(e_pass));
    check({tag, "_err"},  8'(err_v[u]),  8'(e_err));
    check({tag, "_fail"}, 8'(fail_v[u]), 8'(e_fail));
    check({tag, "_bad"},  8'(bad_v[u]),  8'd0);
    check({tag, "_ab0"},  8'(ab_v[u]),   8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    stuck      = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    gsel_v[0]  = 3'd0;
    gsel_v[1]  = 3'd0;
    #3;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    #9 rst_n = 1'b1;
    tick();
    tick();
    check_idle(0, "post_reset");

    sweep(0, 2, 3'd1, -1, 3'd0, 4'b0000, 1'b1, "nand_ok");
    sweep(0, 2, 3'd0, -1, 3'd4, 4'b1111, 1'b0, "and_vs_nand");
    stuck = 1'b1;
    sweep(0, 2, 3'd1, -1, 3'd1, 4'b1000, 1'b0, "nand_stuck1");
    stuck = 1'b0;

    start_v[0] = 1'b1;
    gsel_v[0]  = 3'd7;
    tick();
    start_v[0] = 1'b0;
    tick();
    check("badsel_done", 8'(done_v[0]), 8'd1);
    check("badsel_bad",  8'(bad_v[0]),  8'd1);
    check("badsel_pass", 8'(pass_v[0]), 8'd0);
    check("badsel_ab",   8'(ab_v[0]),   8'd0);
    check("badsel_err",  8'(err_v[0]),  8'd0);
    check("badsel_fail", 8'(fail_v[0]), 8'd0);
    check("badsel_busy", 8'(busy_v[0]), 8'd0);

    sweep(0, 2, 3'd1, 4, 3'd0, 4'b0000, 1'b1, "restart_ignored");

    start_v[0] = 1'b1;
    gsel_v[0]  = 3'd1;
    tick();
    start_v[0] = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check("midreset_ab_before", 8'(ab_v[0]), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "midreset");
    #3 rst_n = 1'b1;
    tick();
    tick();
    check_idle(0, "after_reset");
    sweep(0, 2, 3'd1, -1, 3'd0, 4'b0000, 1'b1, "clean_sweep");

    sweep(1, 0, 3'd1, -1, 3'd0, 4'b0000, 1'b1, "settle0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
